// File: rtl/drp_seq_pkg.sv
// ---------------------------------------------------------------------------
// drp_seq_pkg
// Shared types and constants for the DRP reconfiguration sequencer:
//   - drp_state_t : sequencer FSM states
//   - drp_entry_t : one configuration-ROM entry {addr, mask, data}
//   - ERR_*       : ERR_CODE encodings
//   - CFG_ROM     : register-write tables, one row of entries per config set
// ---------------------------------------------------------------------------
package drp_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RST_HOLD  = 3'd1,
      ST_RD_REQ    = 3'd2,
      ST_RD_WAIT   = 3'd3,
      ST_WR_REQ    = 3'd4,
      ST_WR_WAIT   = 3'd5,
      ST_LOCK_WAIT = 3'd6
   } drp_state_t;

   // mask bit = 1 keeps the bit read back from the DRP, 0 takes it from data
   typedef struct packed {
      logic [6:0]  addr;
      logic [15:0] mask;
      logic [15:0] data;
   } drp_entry_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_DRDY = 2'b01;
   localparam logic [1:0] ERR_LOCK = 2'b10;

   localparam int ROM_NUM_CFG = 4;
   localparam int ROM_ENTRIES = 8;

   localparam drp_entry_t CFG_ROM [ROM_NUM_CFG][ROM_ENTRIES] = '{
      '{ '{7'h08, 16'hF000, 16'h0A00}, '{7'h09, 16'h0000, 16'h1041},
         '{7'h0A, 16'hFF00, 16'h0055}, '{7'h0B, 16'h00FF, 16'hAB00},
         '{7'h0C, 16'h8000, 16'h0C3C}, '{7'h0D, 16'hC000, 16'h2001},
         '{7'h0E, 16'h0F0F, 16'h5050}, '{7'h0F, 16'hFFF0, 16'h0007} },
      '{ '{7'h14, 16'h1000, 16'h0145}, '{7'h15, 16'h8000, 16'h0800},
         '{7'h16, 16'hFC00, 16'h0041}, '{7'h18, 16'h6000, 16'h1F00},
         '{7'h19, 16'h7C00, 16'h00C3}, '{7'h1A, 16'h0000, 16'hBEEF},
         '{7'h4E, 16'h66FF, 16'h1100}, '{7'h4F, 16'h666F, 16'h9000} },
      '{ '{7'h28, 16'h00F0, 16'h1234}, '{7'h29, 16'hFF00, 16'h0033},
         '{7'h13, 16'hF0F0, 16'h0A05}, '{7'h14, 16'h1000, 16'h0208},
         '{7'h15, 16'h8000, 16'h1041}, '{7'h16, 16'hFC00, 16'h0082},
         '{7'h4E, 16'h66FF, 16'h0900}, '{7'h4F, 16'h666F, 16'h1000} },
      '{ '{7'h40, 16'h0001, 16'h5A5A}, '{7'h41, 16'hFFFE, 16'h0001},
         '{7'h42, 16'h0F00, 16'hC0DE}, '{7'h43, 16'h00FF, 16'h7700},
         '{7'h44, 16'hAAAA, 16'h5555}, '{7'h45, 16'h5555, 16'hAAAA},
         '{7'h46, 16'h0000, 16'h0000}, '{7'h47, 16'hFFFF, 16'h0000} }
   };

endpackage

// File: rtl/drp_cfg_rom.sv
// ---------------------------------------------------------------------------
// drp_cfg_rom
// Combinational lookup of one configuration entry.
//   i_sel   : configuration set index
//   i_idx   : entry index within the set
//   o_entry : {addr, mask, data}; all zeros for an index outside the table
// ---------------------------------------------------------------------------
module drp_cfg_rom
   import drp_seq_pkg::*;
#(
   parameter int SEL_W = 2,
   parameter int IDX_W = 4
) (
   input  logic [SEL_W-1:0] i_sel,
   input  logic [IDX_W-1:0] i_idx,
   output drp_entry_t       o_entry
);

   // Constant-index selection keeps the array access in range for any
   // parameterisation; out-of-table indices read as zero.
   always_comb begin
      o_entry = '0;
      for (int s = 0; s < ROM_NUM_CFG; s++) begin
         for (int e = 0; e < ROM_ENTRIES; e++) begin
            if (int'(i_sel) == s && int'(i_idx) == e) begin
               o_entry = CFG_ROM[s][e];
            end
         end
      end
   end

endmodule

// File: rtl/drp_reconfig_seq.sv
// ---------------------------------------------------------------------------
// drp_reconfig_seq
// Reconfigures an ADPLL over its DRP port: holds PLL_RST, performs one
// read-modify-write per ROM entry of the selected set, releases PLL_RST and
// waits for lock.
//   DCLK, RESET      : clock, asynchronous active-high reset
//   START, CFG_SEL   : request and configuration set (sampled in IDLE)
//   BUSY, DONE       : sequence running / one-cycle success pulse
//   ERR, ERR_CODE    : sticky error flag and cause (cleared by next START)
//   DADDR, DI, DEN,
//   DWE, DO, DRDY    : DRP master port
//   LOCKED, PLL_RST  : ADPLL lock input (async) and reset output
//   DBG_STATE        : current FSM state
// DRP handshake: DEN is a single-cycle request; the access is outstanding
// until DRDY is seen in the matching wait state, and no new DEN is issued
// before then. DRDY in any other state is ignored.
// ---------------------------------------------------------------------------
module drp_reconfig_seq
   import drp_seq_pkg::*;
#(
   parameter int NUM_CFG      = 4,
   parameter int ENTRIES      = 8,
   parameter int DRDY_TIMEOUT = 64,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int RST_SETTLE   = 4
) (
   input  logic                       DCLK,
   input  logic                       RESET,
   input  logic                       START,
   input  logic [$clog2(NUM_CFG)-1:0] CFG_SEL,
   output logic                       BUSY,
   output logic                       DONE,
   output logic                       ERR,
   output logic [1:0]                 ERR_CODE,
   output logic [6:0]                 DADDR,
   output logic [15:0]                DI,
   output logic                       DEN,
   output logic                       DWE,
   input  logic [15:0]                DO,
   input  logic                       DRDY,
   input  logic                       LOCKED,
   output logic                       PLL_RST,
   output drp_state_t                 DBG_STATE
);

   localparam int SEL_W   = $clog2(NUM_CFG);
   localparam int IDX_W   = $clog2(ENTRIES) + 1;
   localparam int MAX_A   = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
   localparam int MAX_CNT = (MAX_A > RST_SETTLE) ? MAX_A : RST_SETTLE;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(RST_SETTLE - 1);
   localparam logic [CNT_W-1:0] C_DRDY_LAST   = CNT_W'(DRDY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] C_IDX_LAST    = IDX_W'(ENTRIES - 1);

   drp_state_t        r_state;
   logic [SEL_W-1:0]  r_sel;
   logic [IDX_W-1:0]  r_idx;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_sync1;
   logic              r_sync2;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [1:0]        r_err_code;
   logic [6:0]        r_daddr;
   logic [15:0]       r_di;
   logic              r_den;
   logic              r_dwe;
   logic              r_pll_rst;

   logic [IDX_W-1:0]  w_rom_idx;
   drp_entry_t        w_entry;
   logic [15:0]       w_rmw;

   // In WR_WAIT the lookup runs one entry ahead so the next read's address is
   // ready on the same edge that issues its DEN.
   assign w_rom_idx = (r_state == ST_WR_WAIT) ? r_idx + 1'b1 : r_idx;

   drp_cfg_rom #(
      .SEL_W (SEL_W),
      .IDX_W (IDX_W)
   ) u_rom (
      .i_sel   (r_sel),
      .i_idx   (w_rom_idx),
      .o_entry (w_entry)
   );

   assign w_rmw = (DO & w_entry.mask) | (w_entry.data & ~w_entry.mask);

   // The access counter is cleared on the edge that raises DEN and keeps
   // counting through the REQ cycle, so a timeout fires DRDY_TIMEOUT cycles
   // after DEN. DRDY is tested before the limit, so a DRDY on the final
   // cycle still completes the access.
   always_ff @(posedge DCLK or posedge RESET) begin
      if (RESET) begin
         r_state    <= ST_IDLE;
         r_sel      <= '0;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
         r_daddr    <= '0;
         r_di       <= '0;
         r_den      <= 1'b0;
         r_dwe      <= 1'b0;
         r_pll_rst  <= 1'b0;
      end else begin
         r_sync1 <= LOCKED;
         r_sync2 <= r_sync1;
         r_done  <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (START) begin
                  r_sel      <= CFG_SEL;
                  r_err      <= 1'b0;
                  r_err_code <= ERR_NONE;
                  r_idx      <= '0;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_pll_rst  <= 1'b1;
                  r_state    <= ST_RST_HOLD;
               end
            end

            ST_RST_HOLD: begin
               if (r_cnt == C_SETTLE_LAST) begin
                  r_den   <= 1'b1;
                  r_dwe   <= 1'b0;
                  r_daddr <= w_entry.addr;
                  r_cnt   <= '0;
                  r_state <= ST_RD_REQ;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_RD_REQ: begin
               r_den   <= 1'b0;
               r_cnt   <= r_cnt + 1'b1;
               r_state <= ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
               if (DRDY) begin
                  r_di    <= w_rmw;
                  r_den   <= 1'b1;
                  r_dwe   <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= ST_WR_REQ;
               end else if (r_cnt == C_DRDY_LAST) begin
                  r_err      <= 1'b1;
                  r_err_code <= ERR_DRDY;
                  r_pll_rst  <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_WR_REQ: begin
               r_den   <= 1'b0;
               r_dwe   <= 1'b0;
               r_cnt   <= r_cnt + 1'b1;
               r_state <= ST_WR_WAIT;
            end

            ST_WR_WAIT: begin
               if (DRDY) begin
                  r_idx <= r_idx + 1'b1;
                  r_cnt <= '0;
                  if (r_idx == C_IDX_LAST) begin
                     r_pll_rst <= 1'b0;
                     r_state   <= ST_LOCK_WAIT;
                  end else begin
                     r_den   <= 1'b1;
                     r_dwe   <= 1'b0;
                     r_daddr <= w_entry.addr;
                     r_state <= ST_RD_REQ;
                  end
               end else if (r_cnt == C_DRDY_LAST) begin
                  r_err      <= 1'b1;
                  r_err_code <= ERR_DRDY;
                  r_pll_rst  <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            ST_LOCK_WAIT: begin
               if (r_sync2) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (r_cnt == C_LOCK_LAST) begin
                  r_err      <= 1'b1;
                  r_err_code <= ERR_LOCK;
                  r_busy     <= 1'b0;
                  r_state    <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: begin
               r_den     <= 1'b0;
               r_dwe     <= 1'b0;
               r_pll_rst <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign ERR       = r_err;
   assign ERR_CODE  = r_err_code;
   assign DADDR     = r_daddr;
   assign DI        = r_di;
   assign DEN       = r_den;
   assign DWE       = r_dwe;
   assign PLL_RST   = r_pll_rst;
   assign DBG_STATE = r_state;

endmodule

// File: tb/tb_drp_reconfig_seq.sv
// ---------------------------------------------------------------------------
// tb_drp_reconfig_seq
// Bench for drp_reconfig_seq: a DRP slave model backed by a register array,
// an ADPLL lock model, and a reference that derives the expected DRP access
// stream and completion timing from the ROM tables and the sequencing rules.
// ---------------------------------------------------------------------------
module tb_drp_reconfig_seq;
   import drp_seq_pkg::*;

   localparam int NUM_CFG      = 4;
   localparam int ENTRIES      = 8;
   localparam int DRDY_TIMEOUT = 64;
   localparam int LOCK_TIMEOUT = 4096;
   localparam int RST_SETTLE   = 4;
   localparam int RUN_BUDGET   = 8000;

   logic        DCLK = 1'b0;
   logic        RESET;
   logic        START;
   logic [1:0]  CFG_SEL;
   logic        BUSY, DONE, ERR;
   logic [1:0]  ERR_CODE;
   logic [6:0]  DADDR;
   logic [15:0] DI;
   logic        DEN, DWE;
   logic [15:0] DO;
   logic        DRDY;
   logic        LOCKED;
   logic        PLL_RST;
   drp_state_t  DBG_STATE;

   int n_checks = 0;
   int n_pass   = 0;

   logic [23:0] exp_q[$];
   logic [15:0] mem [128];
   int          rsp_dly   = 1;
   int          rsp_stall = -1;
   int          rsp_acc   = 0;
   logic [15:0] first_wr_di;

   drp_reconfig_seq #(
      .NUM_CFG      (NUM_CFG),
      .ENTRIES      (ENTRIES),
      .DRDY_TIMEOUT (DRDY_TIMEOUT),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .RST_SETTLE   (RST_SETTLE)
   ) dut (
      .DCLK      (DCLK),
      .RESET     (RESET),
      .START     (START),
      .CFG_SEL   (CFG_SEL),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ERR       (ERR),
      .ERR_CODE  (ERR_CODE),
      .DADDR     (DADDR),
      .DI        (DI),
      .DEN       (DEN),
      .DWE       (DWE),
      .DO        (DO),
      .DRDY      (DRDY),
      .LOCKED    (LOCKED),
      .PLL_RST   (PLL_RST),
      .DBG_STATE (DBG_STATE)
   );

   // clock
   always #5 DCLK = ~DCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctrl"}, 32'({BUSY, DONE, ERR, DEN, DWE, PLL_RST}), 32'd0);
      check({tag, "_err_code"}, 32'(ERR_CODE), 32'(ERR_NONE));
      check({tag, "_daddr"}, 32'(DADDR), 32'd0);
      check({tag, "_di"}, 32'(DI), 32'd0);
      check({tag, "_state"}, 32'(DBG_STATE), 32'(ST_IDLE));
   endtask

   // DRP slave: answers each DEN with DRDY rsp_dly cycles later; reads return
   // the array contents, writes update it. The read of entry rsp_stall is
   // never answered.
   initial begin
      logic [6:0] a;
      logic       w;
      int         ent;
      DRDY = 1'b0;
      DO   = 16'h0;
      forever begin
         @(posedge DCLK); #1;
         while (DEN && !RESET) begin
            a   = DADDR;
            w   = DWE;
            ent = rsp_acc / 2;
            rsp_acc++;
            if (w) mem[a] = DI;
            if (!w && ent == rsp_stall) begin
               @(posedge DCLK); #1;
            end else begin
               repeat (rsp_dly) @(posedge DCLK);
               #1;
               DO   = w ? 16'h0 : mem[a];
               DRDY = 1'b1;
               @(posedge DCLK); #1;
               DRDY = 1'b0;
            end
         end
      end
   end

   // One reconfiguration request. dly: DRDY latency; stall: entry whose read
   // never completes (-1 none); lk: LOCKED rise delay after PLL_RST falls
   // (-1 never); restart: pulse START again in WR_WAIT with another CFG_SEL;
   // rst_mid: assert RESET while waiting for the read of entry 3.
   task automatic run(input int sel, input int dly, input int stall, input int lk,
                      input bit restart, input bit rst_mid);
      logic [15:0] shadow [128];
      drp_entry_t  e;
      logic [15:0] rd, wr;
      logic [23:0] got;
      int  t, t_first_den, t_den, t_last_wr_den, t_fall, t_err, t_done;
      int  n_acc, n_done, exp_acc, stall_ent, post;
      bit  drdy_fail, lock_fail, stop, seen_busy, restarted, have_wr, prev_pll;

      // reference: expected access stream from the ROM and the slave contents
      shadow = mem;
      exp_q.delete();
      for (int i = 0; i < ENTRIES; i++) begin
         e  = CFG_ROM[sel][i];
         rd = shadow[e.addr];
         wr = (rd & e.mask) | (e.data & ~e.mask);
         exp_q.push_back({1'b0, e.addr, 16'h0});
         exp_q.push_back({1'b1, e.addr, wr});
         shadow[e.addr] = wr;
      end
      drdy_fail = (stall >= 0) || (dly >= DRDY_TIMEOUT);
      stall_ent = (dly >= DRDY_TIMEOUT) ? 0 : stall;
      lock_fail = !drdy_fail && (lk < 0 || lk + 3 > LOCK_TIMEOUT);
      exp_acc   = drdy_fail ? 2 * stall_ent + 1 : 2 * ENTRIES;

      rsp_dly = dly; rsp_stall = stall; rsp_acc = 0; LOCKED = 1'b0;
      t_first_den = -1; t_den = -1; t_last_wr_den = -1; t_fall = -1;
      t_err = -1; t_done = -1; n_acc = 0; n_done = 0; post = 0;
      stop = 0; seen_busy = 0; restarted = 0; have_wr = 0; prev_pll = 0;
      first_wr_di = 16'h0;

      CFG_SEL = 2'(sel);
      START   = 1'b1;
      @(posedge DCLK); #1;
      START = 1'b0;
      t = 0;
      check("busy_after_start", 32'(BUSY), 32'd1);
      check("pll_rst_after_start", 32'(PLL_RST), 32'd1);

      while (!stop) begin
         if (DEN) begin
            got = {DWE, DADDR, DWE ? DI : 16'h0};
            if (exp_q.size() > 0) check("drp_access", 32'(got), 32'(exp_q.pop_front()));
            else check("drp_extra_access", n_acc + 1, exp_acc);
            n_acc++;
            if (t_first_den < 0) t_first_den = t;
            t_den = t;
            if (DWE) t_last_wr_den = t;
            if (DWE && !have_wr) begin first_wr_di = DI; have_wr = 1; end
         end
         if (prev_pll && !PLL_RST && t_fall < 0) t_fall = t;
         prev_pll = PLL_RST;
         if (ERR && t_err < 0) t_err = t;
         if (DONE) begin n_done++; if (t_done < 0) t_done = t; end
         if (t_fall >= 0 && lk >= 0 && t == t_fall + lk) LOCKED = 1'b1;

         if (START) START = 1'b0;
         if (restart && !restarted && DBG_STATE == ST_WR_WAIT) begin
            CFG_SEL   = 2'((sel + 1) % NUM_CFG);
            START     = 1'b1;
            restarted = 1;
         end

         if (rst_mid && DBG_STATE == ST_RD_WAIT && n_acc >= 7) begin
            #2;
            RESET = 1'b1;
            #1;
            check_reset_outputs("async_reset");
            stop = 1;
         end

         if (BUSY) seen_busy = 1;
         if (seen_busy && !BUSY) post++;
         if (post >= 3 || t >= RUN_BUDGET) stop = 1;
         if (!stop) begin @(posedge DCLK); #1; t++; end
      end
      START = 1'b0;

      if (t >= RUN_BUDGET) check("run_cycle_budget", t, RUN_BUDGET - 1);

      if (rst_mid) begin
         check("restart_seen", 32'(restarted), 32'd1);
         repeat (3) @(posedge DCLK);
         #1;
         check_reset_outputs("reset_held");
         RESET = 1'b0;
      end else begin
         check("access_count", n_acc, exp_acc);
         check("settle_latency", t_first_den, RST_SETTLE);
         check("busy_end", 32'(BUSY), 32'd0);
         check("pll_rst_end", 32'(PLL_RST), 32'd0);
         if (drdy_fail) begin
            check("err", 32'(ERR), 32'd1);
            check("err_code", 32'(ERR_CODE), 32'(ERR_DRDY));
            check("drdy_timeout_latency", t_err - t_den, DRDY_TIMEOUT);
            check("pll_rst_drop_on_err", t_fall - t_den, DRDY_TIMEOUT);
            check("done_count", n_done, 0);
         end else begin
            check("pll_rst_fall_latency", t_fall - t_last_wr_den, dly + 1);
            if (lock_fail) begin
               check("err", 32'(ERR), 32'd1);
               check("err_code", 32'(ERR_CODE), 32'(ERR_LOCK));
               check("lock_timeout_latency", t_err - t_fall, LOCK_TIMEOUT);
               check("done_count", n_done, 0);
            end else begin
               check("err", 32'(ERR), 32'd0);
               check("err_code", 32'(ERR_CODE), 32'(ERR_NONE));
               check("done_count", n_done, 1);
               check("done_latency", t_done - t_fall, lk + 3);
            end
         end
      end
      LOCKED = 1'b0;
      repeat (10) @(posedge DCLK);
      #1;
   endtask

   // main sequence
   initial begin
      int sel;
      RESET   = 1'b0;
      START   = 1'b0;
      CFG_SEL = 2'd0;
      LOCKED  = 1'b0;
      for (int a = 0; a < 128; a++) mem[a] = 16'($urandom);
      #1;
      RESET = 1'b1;
      repeat (3) @(posedge DCLK);
      #1;
      check_reset_outputs("por");
      RESET = 1'b0;
      repeat (2) @(posedge DCLK);
      #1;

      // directed: set 2, DRDY after 3 cycles, lock 100 cycles after PLL_RST
      // falls; entry 0 reads back all ones to exercise the merge
      mem[CFG_ROM[2][0].addr] = 16'hFFFF;
      run(2, 3, -1, 100, 0, 0);
      check("rmw_first_write",
            32'(first_wr_di), 32'((16'hFFFF & 16'h00F0) | (16'h1234 & ~16'h00F0)));

      // randomized successful runs
      for (int r = 0; r < 5; r++) begin
         sel = int'($urandom_range(0, NUM_CFG - 1));
         run(sel, int'($urandom_range(1, 8)), -1, int'($urandom_range(0, 150)), 0, 0);
      end

      // DRDY boundaries: never answered on entry 5, last-cycle DRDY, one late
      run(int'($urandom_range(0, NUM_CFG - 1)), int'($urandom_range(1, 6)), 5, 20, 0, 0);
      run(1, DRDY_TIMEOUT - 1, -1, 10, 0, 0);
      run(3, DRDY_TIMEOUT, -1, 10, 0, 0);

      // lock boundaries: never, last observable cycle, one late
      run(0, 2, -1, -1, 0, 0);
      run(2, 1, -1, LOCK_TIMEOUT - 3, 0, 0);
      run(1, 1, -1, LOCK_TIMEOUT - 2, 0, 0);

      // START while busy is ignored, then reset mid-access
      run(1, 4, -1, 50, 1, 1);

      // sequencer recovers after the mid-sequence reset
      run(int'($urandom_range(0, NUM_CFG - 1)), 2, -1, 30, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
